// File: rtl/mwc_pkg.sv
// Shared types and constants for the match window counter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mwc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } mwc_state_e;

    // Largest value a w-bit saturating counter can hold.
    function automatic logic [31:0] sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Latency: count updates at the edge after clear/load/inc; sat is combinational on the count.
// Backpressure: none; an increment at saturation is silently dropped (caller watches o_sat).
module sat_counter
    import mwc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_sat
);

    localparam logic [W-1:0] MAX_CNT = W'(sat_max(W));

    logic [W-1:0] r_count;

    assign o_count = r_count;
    assign o_sat   = (r_count == MAX_CNT);

    // Clear wins over load, load wins over increment; increments stop at MAX_CNT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses over a programmable window; reports total, flags threshold alarm.
// Latency: report valid the cycle after the last window sample; alarm one cycle after the crossing sample.
// Backpressure: report held stable until rpt_ready; counting pauses in REPORT (MWC_CARRY_EN carries matches over).
module match_window_counter
    import mwc_pkg::*;
#(
    parameter int WINDOW_W = 16,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                match_in,
    input  logic                enable,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic [CNT_W-1:0]    threshold,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [CNT_W-1:0]    rpt_count,
    output logic                rpt_overflow,
    output logic                alarm,
    output logic                busy
);

    mwc_state_e          r_state, w_state_nxt;
    logic [WINDOW_W-1:0] r_timer, w_timer_nxt;
    logic [CNT_W-1:0]    r_thresh, w_thresh_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic [CNT_W-1:0]    r_rpt_count, w_rpt_count_nxt;
    logic                r_rpt_ovf, w_rpt_ovf_nxt;
    logic                r_alarm, w_alarm_nxt;
    logic                r_busy;

    logic                w_handshake;
    logic                w_load;
    logic                w_cnt_clear;
    logic                w_cnt_inc;
    logic [CNT_W-1:0]    w_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_cnt_sat;
    logic [CNT_W-1:0]    w_seed;
    logic                w_seed_ovf;
    logic [WINDOW_W-1:0] w_len_eff;

    // A zero-length window still samples one cycle.
    assign w_len_eff   = (window_len == '0) ? WINDOW_W'(1) : window_len;
    assign w_handshake = (r_state == REPORT) && rpt_ready;
    // A new window starts from IDLE, or straight out of an accepted report.
    assign w_load      = enable && ((r_state == IDLE) || w_handshake);
    assign w_cnt_clear = (r_state == COUNT) && !enable;
    assign w_cnt_inc   = (r_state == COUNT) && enable && match_in;
    assign w_cnt_next  = (w_cnt_inc && !w_cnt_sat) ? (w_cnt + CNT_W'(1)) : w_cnt;

    sat_counter #(
        .W (CNT_W)
    ) u_count (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_cnt_clear),
        .i_load     (w_load),
        .i_load_val (w_seed),
        .i_inc      (w_cnt_inc),
        .o_count    (w_cnt),
        .o_sat      (w_cnt_sat)
    );

`ifdef MWC_CARRY_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic             w_carry_clear;
    logic             w_carry_inc;
    logic [CNT_W-1:0] w_carry;
    logic [CNT_W-1:0] w_carry_next;
    logic             w_carry_sat;

    // Carry only lives while a report waits; it is consumed (or dropped) as REPORT is left.
    assign w_carry_clear = (r_state != REPORT) || w_handshake;
    assign w_carry_inc   = (r_state == REPORT) && match_in;
    assign w_carry_next  = (w_carry_inc && !w_carry_sat) ? (w_carry + CNT_W'(1)) : w_carry;

    sat_counter #(
        .W (CNT_W)
    ) u_carry (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_carry_clear),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_carry_inc),
        .o_count    (w_carry),
        .o_sat      (w_carry_sat)
    );

    // Seed includes a match landing on the handshake cycle itself.
    assign w_seed     = w_carry_next;
    assign w_seed_ovf = w_carry_sat || (w_carry_inc && (w_carry_next == CNT_MAX));
`else
    assign w_seed     = '0;
    assign w_seed_ovf = 1'b0;
`endif

    // Next-state and next-output decode for the window FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_thresh_nxt    = r_thresh;
        w_ovf_nxt       = r_ovf;
        w_rpt_count_nxt = r_rpt_count;
        w_rpt_ovf_nxt   = r_rpt_ovf;
        w_alarm_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                // match_in ignored; w_load handles the start.
            end
            COUNT: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer - WINDOW_W'(1);
                    if (match_in && w_cnt_sat) begin
                        w_ovf_nxt = 1'b1;
                    end
                    // Fires only on the increment that lands on threshold, so at most
                    // once per window and never when the seed already sits at/above it.
                    if ((w_cnt_next != w_cnt) && (w_cnt_next == r_thresh) && (r_thresh != '0)) begin
                        w_alarm_nxt = 1'b1;
                    end
                    if (r_timer == WINDOW_W'(1)) begin
                        w_state_nxt     = REPORT;
                        w_rpt_count_nxt = w_cnt_next;
                        w_rpt_ovf_nxt   = w_ovf_nxt;
                    end
                end
            end
            REPORT: begin
                if (rpt_ready && !enable) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt  = COUNT;
            w_timer_nxt  = w_len_eff;
            w_thresh_nxt = threshold;
            w_ovf_nxt    = w_seed_ovf;
        end
    end

    // State and registered outputs; reset drops any window or pending report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_thresh    <= '0;
            r_ovf       <= 1'b0;
            r_rpt_count <= '0;
            r_rpt_ovf   <= 1'b0;
            r_alarm     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_thresh    <= w_thresh_nxt;
            r_ovf       <= w_ovf_nxt;
            r_rpt_count <= w_rpt_count_nxt;
            r_rpt_ovf   <= w_rpt_ovf_nxt;
            r_alarm     <= w_alarm_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign rpt_valid    = (r_state == REPORT);
    assign rpt_count    = r_rpt_count;
    assign rpt_overflow = r_rpt_ovf;
    assign alarm        = r_alarm;
    assign busy         = r_busy;

endmodule

// File: tb/tb_match_window_counter.sv
// Bench for match_window_counter: an 8-bit and a 4-bit count instance share one stimulus.
// Latency: reports are compared at the cycle after the last sample of each window.
// Backpressure: rpt_ready is held low through each window and driven explicitly per scenario.
module tb_match_window_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        match_in;
    logic        enable;
    logic [15:0] window_len;
    logic [7:0]  threshold;
    logic        rpt_ready;

    logic        rpt_valid, rpt_overflow, alarm, busy;
    logic [7:0]  rpt_count;
    logic        rpt_valid4, rpt_overflow4, alarm4, busy4;
    logic [3:0]  rpt_count4;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] exp8;
    logic [4:0] exp4;

    int alarm_cnt;
    int alarm_at;
    bit early_valid;

    always #5 clk = ~clk;

    match_window_counter #(.WINDOW_W(16), .CNT_W(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .match_in     (match_in),
        .enable       (enable),
        .window_len   (window_len),
        .threshold    (threshold),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_count    (rpt_count),
        .rpt_overflow (rpt_overflow),
        .alarm        (alarm),
        .busy         (busy)
    );

    match_window_counter #(.WINDOW_W(16), .CNT_W(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .match_in     (match_in),
        .enable       (enable),
        .window_len   (window_len),
        .threshold    (threshold[3:0]),
        .rpt_valid    (rpt_valid4),
        .rpt_ready    (rpt_ready),
        .rpt_count    (rpt_count4),
        .rpt_overflow (rpt_overflow4),
        .alarm        (alarm4),
        .busy         (busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: saturating count of the first n pattern bits, starting from seed.
    function automatic void push_exp(input int n, input logic [31:0] pat, input int seed);
        int c8 = seed;
        int c4 = seed;
        bit o8 = 1'b0;
        bit o4 = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (pat[i]) begin
                if (c8 == 255) o8 = 1'b1; else c8++;
                if (c4 == 15)  o4 = 1'b1; else c4++;
            end
        end
        q8.push_back({o8, 8'(c8)});
        q4.push_back({o4, 4'(c4)});
    endfunction

    // Drives one window; start=0 continues a window already loaded by a handshake.
    task automatic run_window(input int len, input logic [7:0] thr, input logic [31:0] pat,
                              input int n_samp, input bit start);
        if (start) begin
            enable     = 1'b1;
            window_len = 16'(len);
            threshold  = thr;
            match_in   = 1'b0;
            rpt_ready  = 1'b0;
            tick();
        end
        alarm_cnt   = 0;
        alarm_at    = -1;
        early_valid = 1'b0;
        for (int i = 0; i < n_samp; i++) begin
            match_in = pat[i];
            tick();
            if (alarm) begin
                alarm_cnt++;
                alarm_at = i;
            end
            if ((i < n_samp - 1) && rpt_valid) early_valid = 1'b1;
        end
        match_in = 1'b0;
    endtask

    task automatic finish_report(input bit en_next);
        rpt_ready = 1'b1;
        enable    = en_next;
        tick();
        rpt_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; match_in = 1'b0; enable = 1'b0; window_len = '0; threshold = '0; rpt_ready = 1'b0;
        #3;
        checks++;
        if ({rpt_valid, rpt_count, rpt_overflow, alarm, busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset8 got %h exp 0", {rpt_valid, rpt_count, rpt_overflow, alarm, busy});
        end
        checks++;
        if ({rpt_valid4, rpt_count4, rpt_overflow4, alarm4, busy4} !== 8'h0) begin
            errors++;
            $display("FAIL reset4 got %h exp 0", {rpt_valid4, rpt_count4, rpt_overflow4, alarm4, busy4});
        end
        #13;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        push_exp(8, 32'h24, 0);
        run_window(8, 8'd0, 32'h24, 8, 1'b1);
        checks++;
        if (early_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", early_valid); end
        checks++;
        if (rpt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", rpt_valid); end
        checks++;
        if (alarm_cnt !== 0) begin errors++; $display("FAIL basic_alarm got %0d exp 0", alarm_cnt); end
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_overflow, rpt_count} !== exp8) begin errors++; $display("FAIL basic_rpt8 got %h exp %h", {rpt_overflow, rpt_count}, exp8); end
        checks++;
        if ({rpt_overflow4, rpt_count4} !== exp4) begin errors++; $display("FAIL basic_rpt4 got %h exp %h", {rpt_overflow4, rpt_count4}, exp4); end
        finish_report(1'b0);
        checks++;
        if ({busy, rpt_valid} !== 2'b00) begin errors++; $display("FAIL basic_idle got %b exp 00", {busy, rpt_valid}); end
    endtask

    task automatic test_back_to_back();
        push_exp(6, 32'h15, 0);
        run_window(6, 8'd0, 32'h15, 6, 1'b1);
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        for (int i = 0; i < 5; i++) begin
            enable = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({rpt_valid, rpt_overflow, rpt_count} !== {1'b1, exp8}) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got %h exp %h", i, {rpt_valid, rpt_overflow, rpt_count}, {1'b1, exp8});
            end
        end
        window_len = 16'd4;
        threshold  = 8'd0;
        finish_report(1'b1);
        checks++;
        if ({busy, rpt_valid} !== 2'b10) begin errors++; $display("FAIL b2b_count got %b exp 10", {busy, rpt_valid}); end
        push_exp(4, 32'h2, 0);
        run_window(4, 8'd0, 32'h2, 4, 1'b0);
        checks++;
        if (rpt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b exp 1", rpt_valid); end
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_overflow, rpt_count} !== exp8) begin errors++; $display("FAIL b2b_rpt8 got %h exp %h", {rpt_overflow, rpt_count}, exp8); end
        finish_report(1'b0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b exp 0", busy); end
    endtask

    task automatic test_saturate();
        push_exp(20, 32'hF_FFFF, 0);
        run_window(20, 8'd0, 32'hF_FFFF, 20, 1'b1);
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_valid, rpt_overflow, rpt_count} !== {1'b1, exp8}) begin
            errors++; $display("FAIL sat_rpt8 got %h exp %h", {rpt_valid, rpt_overflow, rpt_count}, {1'b1, exp8});
        end
        checks++;
        if ({rpt_valid4, rpt_overflow4, rpt_count4} !== {1'b1, exp4}) begin
            errors++; $display("FAIL sat_rpt4 got %h exp %h", {rpt_valid4, rpt_overflow4, rpt_count4}, {1'b1, exp4});
        end
        finish_report(1'b0);
    endtask

    task automatic test_alarm();
        push_exp(10, 32'hD2, 0);
        run_window(10, 8'd3, 32'hD2, 10, 1'b1);
        checks++;
        if ((alarm_cnt !== 1) || (alarm_at !== 6)) begin
            errors++; $display("FAIL alarm_mid got cnt %0d at %0d exp cnt 1 at 6", alarm_cnt, alarm_at);
        end
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_valid, rpt_overflow, rpt_count} !== {1'b1, exp8}) begin
            errors++; $display("FAIL alarm_rpt8 got %h exp %h", {rpt_valid, rpt_overflow, rpt_count}, {1'b1, exp8});
        end
        finish_report(1'b0);
        push_exp(4, 32'hA, 0);
        run_window(4, 8'd2, 32'hA, 4, 1'b1);
        checks++;
        if ((alarm_cnt !== 1) || (alarm_at !== 3) || (rpt_valid !== 1'b1)) begin
            errors++; $display("FAIL alarm_last got cnt %0d at %0d valid %0b exp cnt 1 at 3 valid 1", alarm_cnt, alarm_at, rpt_valid);
        end
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_overflow, rpt_count} !== exp8) begin errors++; $display("FAIL alarm_last_rpt got %h exp %h", {rpt_overflow, rpt_count}, exp8); end
        finish_report(1'b0);
    endtask

    task automatic test_abort();
        bit seen;
        run_window(10, 8'd1, 32'h0, 3, 1'b1);
        match_in = 1'b1;
        enable   = 1'b0;
        tick();
        match_in = 1'b0;
        checks++;
        if ({busy, rpt_valid, alarm} !== 3'b000) begin errors++; $display("FAIL abort_idle got %b exp 000", {busy, rpt_valid, alarm}); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rpt_valid || alarm) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_report got %0b exp 0", seen); end
    endtask

    task automatic test_reset_report();
        push_exp(3, 32'h1, 0);
        run_window(3, 8'd0, 32'h1, 3, 1'b1);
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_valid, rpt_overflow, rpt_count} !== {1'b1, exp8}) begin
            errors++; $display("FAIL rstrpt_pre got %h exp %h", {rpt_valid, rpt_overflow, rpt_count}, {1'b1, exp8});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rpt_valid, rpt_count, rpt_overflow, alarm, busy} !== 12'h0) begin
            errors++; $display("FAIL rstrpt_async got %h exp 0", {rpt_valid, rpt_count, rpt_overflow, alarm, busy});
        end
        enable = 1'b0;
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_len_zero();
        push_exp(1, 32'h1, 0);
        run_window(0, 8'd0, 32'h1, 1, 1'b1);
        checks++;
        if (rpt_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %0b exp 1", rpt_valid); end
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_overflow, rpt_count} !== exp8) begin errors++; $display("FAIL len0_rpt got %h exp %h", {rpt_overflow, rpt_count}, exp8); end
        finish_report(1'b0);
    endtask

    task automatic test_carry();
        int seed;
`ifdef MWC_CARRY_EN
        seed = 2;
`else
        seed = 0;
`endif
        run_window(5, 8'd0, 32'h0, 5, 1'b1);
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        for (int i = 0; i < 4; i++) begin
            match_in = ~i[0];
            tick();
        end
        match_in   = 1'b0;
        window_len = 16'd4;
        threshold  = 8'd0;
        finish_report(1'b1);
        push_exp(4, 32'h1, seed);
        run_window(4, 8'd0, 32'h1, 4, 1'b0);
        exp8 = q8.pop_front(); exp4 = q4.pop_front();
        checks++;
        if ({rpt_valid, rpt_overflow, rpt_count} !== {1'b1, exp8}) begin
            errors++; $display("FAIL carry_rpt8 got %h exp %h", {rpt_valid, rpt_overflow, rpt_count}, {1'b1, exp8});
        end
        checks++;
        if ({rpt_overflow4, rpt_count4} !== exp4) begin errors++; $display("FAIL carry_rpt4 got %h exp %h", {rpt_overflow4, rpt_count4}, exp4); end
        finish_report(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturate();
        test_alarm();
        test_abort();
        test_reset_report();
        test_len_zero();
        test_carry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
- Downstream consumer of the serial sequence detector's one-cycle match pulse.
- Counts match pulses over a programmable window of N clock cycles and reports the total through a valid/ready handshake.
- Raises a one-cycle alarm when the in-window count reaches a programmable threshold.
- Feeds the status/CSR collection logic.

Parameters:
- WINDOW_W, 16: width of window_len and of the window timer.
- CNT_W, 8: width of the match count, threshold and report.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- match_in  in  1  match pulse from the detector, sampled every cycle.
- enable  in  1  window counting enabled; level.
- window_len  in  WINDOW_W  window length in cycles, sampled on window start; 0 is treated as 1.
- threshold  in  CNT_W  alarm threshold, sampled on window start; 0 disables the alarm.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts the report.
- rpt_count  out  CNT_W  matches counted in the window.
- rpt_overflow  out  1  count saturated during the window.
- alarm  out  1  one-cycle pulse when the count reaches threshold.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, clk not required):
  - State goes to IDLE.
  - rpt_valid, rpt_count, rpt_overflow, alarm and busy are 0.
  - Timer, count, carry and latched threshold are 0.
- FSM states: IDLE, COUNT, REPORT. Registered outputs; no combinational path from input to output except rpt_valid, which is decoded from state.
- IDLE:
  - enable=1 at an edge loads timer=max(window_len,1), latches threshold, clears count and overflow, and moves to COUNT.
  - match_in is ignored in IDLE.
- COUNT:
  - Each edge samples match_in. If 1, count increments, saturating at 2^CNT_W-1.
  - An increment attempted at saturation sets overflow (sticky for the window).
  - The timer decrements at each edge. At the edge where timer==1 (the last sample), the state moves to REPORT.
  - rpt_count/rpt_overflow load the final value, including that last sample.
  - A window of N therefore samples exactly N cycles. rpt_valid rises the cycle after the last sample.
- Alarm:
  - Asserts for exactly one cycle, registered, in the cycle after the sample that makes count == threshold (threshold != 0).
  - At most once per window. Can fire on the final sample: alarm and rpt_valid then assert in the same cycle.
- enable=0 during COUNT: at the next edge, abort to IDLE. No report and no alarm is produced; count is discarded.
- REPORT:
  - rpt_valid=1. rpt_count/rpt_overflow are held stable until handshake (rpt_valid & rpt_ready at an edge).
  - On handshake with enable=1, reload as in IDLE and enter COUNT directly, giving a back-to-back window with zero idle cycles.
  - On handshake with enable=0, go to IDLE.
  - enable is ignored while waiting in REPORT; the report is never withdrawn.
- Matches arriving in REPORT are handled per the optional feature.
- Reset mid-window or mid-REPORT drops everything immediately.

Optional Feature:
- MWC_CARRY_EN defined:
  - A saturating carry counter accumulates match_in samples during REPORT, including the handshake cycle.
  - On reload to COUNT, count is seeded with carry, then carry is cleared. If the seed is ≥ threshold, the alarm does not fire for that window.
  - Carry saturation sets the new window's overflow.
  - Carry is cleared on entry to IDLE.
- MWC_CARRY_EN undefined: matches during REPORT and IDLE are dropped; no carry logic exists.

Decomposition:
- Package mwc_pkg: state enum typedef (IDLE=2'd0, COUNT=2'd1, REPORT=2'd2) and the saturating max-count constant function.
- Sub-module sat_counter: parameterised width, with clear, load, inc, count and sat outputs. It is instanced for count and, under MWC_CARRY_EN, for carry.

Test Plan:
- window_len=8, threshold=0, rpt_ready=1, match_in=1 on samples 2 and 5: rpt_valid rises 1 cycle after sample 7, rpt_count=2, rpt_overflow=0, alarm never asserts.
- rpt_ready=0 for 5 cycles in REPORT, count=3: rpt_valid/rpt_count stable at 3 throughout. On ready=1 with enable=1, busy stays 1 and COUNT starts the next cycle; with enable=0, IDLE and busy=0.
- CNT_W=4, window_len=20, match_in=1 every cycle: rpt_count=15, rpt_overflow=1.
- threshold=3, matches on samples 1, 4, 6, 7 of a 10-cycle window: alarm is high exactly in the cycle after sample 6, and rpt_count=4.
- enable dropped at sample 3 of a 10-cycle window: IDLE, rpt_valid never asserts. Separately, reset asserted during REPORT: all outputs 0 asynchronously. window_len=0: exactly one sample, rpt_valid on the next cycle.
- MWC_CARRY_EN: 2 matches during a stalled REPORT, then back-to-back window of 4 with 1 match: rpt_count=3. Without the macro: rpt_count=1.
